// File: rtl/mac_acc_readout.sv
// Drain-side reader for the four-lane MAC accumulator.
// Snapshots the lanes and serialises them as a framed word stream.
module mac_acc_readout #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_ACC_WIDTH  = 4*MAC_MIN_WIDTH,
  parameter bit CLEAR_ON_READ  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  input  logic [MAC_ACC_WIDTH-1:0]  acc0,
  input  logic [MAC_ACC_WIDTH-1:0]  acc1,
  input  logic [MAC_ACC_WIDTH-1:0]  acc2,
  input  logic [MAC_ACC_WIDTH-1:0]  acc3,
  input  logic                      start,
  output logic [MAC_ACC_WIDTH-1:0]  dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic [1:0]                dout_idx,
  output logic                      busy,
  output logic                      overrun,
  output logic                      acc_cset
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_DUAL   = 2'b01;
  localparam logic [1:0] M_QUAD   = 2'b10;

  logic [0:0]               state;
  logic [1:0]               wc;
  logic [1:0]               mode;
  logic [1:0]               eff_mode;
  logic [MAC_ACC_WIDTH-1:0] snap [4];
  logic                     take;
  logic                     hs;

  assign take = (state == IDLE) && start;
  assign hs   = (state == SEND) && dout_ready;

  // Multiply-only and reserved modes frame as independent words.
  always_comb begin
    eff_mode = cfg[1:0];
    if (!cfg[2] || cfg[1:0] == 2'b11)
      eff_mode = M_SINGLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wc       <= 2'd0;
      mode     <= M_SINGLE;
      overrun  <= 1'b0;
      acc_cset <= 1'b0;
      for (int i = 0; i < 4; i++)
        snap[i] <= '0;
    end else begin
      acc_cset <= CLEAR_ON_READ && take;
      if (start && state == SEND)
        overrun <= 1'b1;
      if (take) begin
        snap[0] <= acc0;
        snap[1] <= acc1;
        snap[2] <= acc2;
        snap[3] <= acc3;
        mode    <= eff_mode;
        wc      <= 2'd0;
        state   <= SEND;
      end else if (hs) begin
        wc <= wc + 2'd1;
        if (wc == 2'd3)
          state <= IDLE;
      end
    end
  end

  assign busy       = (state == SEND);
  assign dout_valid = busy;

  always_comb begin
    dout      = '0;
    dout_idx  = 2'd0;
    dout_last = 1'b0;
    if (busy) begin
      dout = snap[wc];
      unique case (1'b1)
        mode == M_DUAL: begin
          dout_idx  = {1'b0, wc[1]};
          dout_last = wc[0];
        end
        mode == M_QUAD: begin
          dout_idx  = 2'd0;
          dout_last = &wc;
        end
        default: begin
          dout_idx  = wc;
          dout_last = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_acc_readout.md
# mac_acc_readout

Drain-side reader for the four-lane MAC accumulator block. On request, it snapshots the four `MAC_ACC_WIDTH` accumulator lanes and their configuration. It then serialises them, lane 0 first, onto a single-word valid/ready stream with result framing derived from the single/dual/quad mode. It sits between the accumulator outputs and the fabric or host readback path, and can optionally pulse the accumulator's config-set to restart accumulation after capture.

## Interface
Parameters:
- `MAC_CONF_WIDTH`, 3: config width; bit 2 = accumulate enable, bits [1:0] = mode (00 single, 01 dual, 10 quad, 11 reserved).
- `MAC_MIN_WIDTH`, 8: minimum operand width.
- `MAC_ACC_WIDTH`, 4*MAC_MIN_WIDTH: lane and stream word width.
- `CLEAR_ON_READ`, 1: when 1, `acc_cset` pulses on capture; when 0, `acc_cset` is tied low.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `cfg` in MAC_CONF_WIDTH: live accumulator configuration.
- `acc0`..`acc3` in MAC_ACC_WIDTH each: accumulator lane outputs.
- `start` in 1: capture request, sampled each cycle.
- `dout` out MAC_ACC_WIDTH: stream data word.
- `dout_valid` out 1: stream word valid.
- `dout_ready` in 1: downstream accepts the word.
- `dout_last` out 1: final word of the current result.
- `dout_idx` out 2: result index of the current word.
- `busy` out 1: snapshot in progress or not yet drained.
- `overrun` out 1: sticky flag for a dropped `start`.
- `acc_cset` out 1: one-cycle config-set request to the accumulator.

## Operation
- FSM states: IDLE, SEND. A 2-bit word counter `wc` selects the snapshot lane.
- IDLE & `start`=1 at edge N:
  - Register `acc0..acc3` into snapshot regs S0..S3.
  - Register the effective mode into mode reg M.
  - `wc` ← 0; state ← SEND.
  - `acc_cset` ← 1 for exactly one cycle if CLEAR_ON_READ=1.
- Effective mode:
  - `cfg[2]`=0 (multiply-only) → single.
  - `cfg[1:0]`=11 → single.
  - Otherwise `cfg[1:0]`.
- SEND outputs:
  - `dout_valid`=1; `dout`=S[wc].
  - `dout`, `dout_last`, `dout_idx` hold stable while `dout_valid & ~dout_ready`.
- Framing per `wc` = 0,1,2,3:
  - Single: `dout_idx` = 0,1,2,3; `dout_last` = 1,1,1,1.
  - Dual: `dout_idx` = 0,0,1,1; `dout_last` = 0,1,0,1. Each 2*MAC_ACC_WIDTH result is sent low word first.
  - Quad: `dout_idx` = 0,0,0,0; `dout_last` = 0,0,0,1. The 4*MAC_ACC_WIDTH result is sent least significant word first.
- Handshake (`dout_valid & dout_ready`): `wc` increments. When the handshake is on `wc`=3, state ← IDLE and `dout_valid` ← 0.
- `start` while in SEND, including the final-handshake cycle: ignored, and `overrun` ← 1. `overrun` is cleared only by `rst`.
- `busy` = (state == SEND).
- The snapshot is immune to lane or `cfg` changes after capture.
- No arithmetic: words pass unmodified, with no sign extension or truncation.

## Timing
- Reset values:
  - `dout`=0, `dout_valid`=0, `dout_last`=0, `dout_idx`=0.
  - `busy`=0, `overrun`=0, `acc_cset`=0.
  - State IDLE, `wc`=0, S0..S3=0, M=single.
- `rst` overrides everything, including mid-SEND. The burst is abandoned and outputs go to reset values at the next edge.
- Capture latency: `start` sampled at edge N → `dout_valid`=1, `busy`=1, `acc_cset`=1 during cycle N+1. `acc_cset` is 0 again at N+2.
- With `dout_ready` held high, a burst is 4 consecutive valid cycles (N+1..N+4). `busy`=0 at N+5.
- The earliest next capture is `start` sampled at edge N+5, giving a minimum spacing of 5 cycles per burst.
- `dout_ready` may toggle arbitrarily. `dout_valid` never drops before its handshake.
- `dout_ready` asserted while IDLE has no effect.

## Test plan
- Single, full throughput:
  - Stimulus: acc0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; `cfg`=100; `start` pulse; `dout_ready`=1.
  - Response: 4 words in lane order on consecutive cycles, `dout_idx` 0,1,2,3, `dout_last`=1 on each, and `acc_cset` for one cycle at N+1.
- Dual with backpressure:
  - Stimulus: `cfg`=101; `dout_ready` alternating 0/1.
  - Response: `dout_idx` 0,0,1,1 and `dout_last` 0,1,0,1. Each word stays stable across ready-low cycles. The burst takes 8 valid cycles.
- Quad with snapshot isolation:
  - Stimulus: `cfg`=110; change acc0..3 to 0xDEADBEEF on the cycle after capture.
  - Response: the original captured values stream out, `dout_last` only on the 4th word.
- Mode coercion:
  - Stimulus: `cfg`=010, then `cfg`=111.
  - Response: both framed as single (`dout_idx` 0..3, `dout_last` on all).
- Overrun:
  - Stimulus: second `start` while busy, including on the final-handshake cycle.
  - Response: no new capture, `overrun`=1 and sticky. A `start` after `busy`=0 is accepted normally.
- Reset mid-burst:
  - Stimulus: assert `rst` after 2 handshakes.
  - Response: next cycle `dout_valid`=0, `busy`=0, `overrun`=0. A subsequent `start` produces a fresh 4-word burst from `wc`=0.
